// File: rtl/scoreboard_regfile_if.sv
// Register-file port bundle: write, set-busy and NRD read ports plus Ready.
// Purely a wiring container; adds no latency.
// No backpressure: the master drives requests every cycle, the slave answers combinationally.
interface scoreboard_regfile_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic                  Ready;
  logic                  RegWrite;
  logic [AW-1:0]         WriteAddr;
  logic [XLEN-1:0]       WriteData;
  logic                  SetBusy;
  logic [AW-1:0]         SetBusyAddr;
  logic [NRD*AW-1:0]     ReadAddr;
  logic [NRD*XLEN-1:0]   ReadData;
  logic [NRD-1:0]        ReadBusy;

  // Requester side (pipeline front end)
  modport master (
    input  Ready, ReadData, ReadBusy,
    output RegWrite, WriteAddr, WriteData, SetBusy, SetBusyAddr, ReadAddr
  );

  // Register-file side
  modport slave (
    output Ready, ReadData, ReadBusy,
    input  RegWrite, WriteAddr, WriteData, SetBusy, SetBusyAddr, ReadAddr
  );
endinterface

// File: rtl/scoreboard_regfile.sv
// Register file with per-register busy (scoreboard) bits, x0 hardwired to zero, optional write forwarding.
// Reads are combinational (zero latency); writes and busy updates land at the next rising edge.
// No backpressure; Ready stays low for NREGS edges after reset while the file self-clears.
module scoreboard_regfile #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input logic                clk,
  input logic                rst,
  scoreboard_regfile_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic [XLEN-1:0]  regs_q [NREGS];

  logic run;
  logic wr_en;
  logic sb_en;

  // Requests only take effect once the clear sweep is done; x0 targets are dropped here.
  assign run   = (state_q == ST_RUN);
  assign wr_en = run && bus.RegWrite && (bus.WriteAddr != '0);
  assign sb_en = run && bus.SetBusy  && (bus.SetBusyAddr != '0);
  assign bus.Ready = run;

  // Next state: sweep counter during CLEAR; busy clear-then-set in RUN so SetBusy wins a collision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (!run) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == AW'(NREGS - 1)) state_d = ST_RUN;
    end else begin
      if (wr_en) busy_d[bus.WriteAddr]   = 1'b0;
      if (sb_en) busy_d[bus.SetBusyAddr] = 1'b1;
    end
  end

  // Control state with synchronous reset; register contents are left to the clear sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Storage: zero one entry per edge while clearing, otherwise accept the write port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run) begin
        regs_q[cnt_q] <= '0;
      end else if (wr_en) begin
        regs_q[bus.WriteAddr] <= bus.WriteData;
      end
    end
  end

  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [AW-1:0]       ra;
  logic                hit;

  // Read ports: x0 and not-ready read as zero; a same-cycle write to the address forwards and hides busy.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    hit     = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      ra  = bus.ReadAddr[p*AW +: AW];
      hit = (BYPASS != 0) && wr_en && (bus.WriteAddr == ra);
      if (run && (ra != '0)) begin
        rd_data[p*XLEN +: XLEN] = hit ? bus.WriteData : regs_q[ra];
        rd_busy[p]              = busy_q[ra] && !hit;
      end
    end
  end

  assign bus.ReadData = rd_data;
  assign bus.ReadBusy = rd_busy;
endmodule

// File: tb/tb_scoreboard_regfile.sv
// Bench for scoreboard_regfile: one BYPASS=1 and one BYPASS=0 instance share identical stimulus.
// An abstract model (edge counter, register array, busy vector) is compared every negedge,
// and directed scenarios pin literal values.
module tb_scoreboard_regfile;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;

  logic clk;
  logic rst;
  logic        reg_write;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        set_busy;
  logic [4:0]  sbaddr;
  logic [4:0]  ra0, ra1;

  int checks = 0;
  int errors = 0;

  scoreboard_regfile_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) if1 ();
  scoreboard_regfile_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) if0 ();

  assign if1.RegWrite    = reg_write;
  assign if1.WriteAddr   = waddr;
  assign if1.WriteData   = wdata;
  assign if1.SetBusy     = set_busy;
  assign if1.SetBusyAddr = sbaddr;
  assign if1.ReadAddr    = {ra1, ra0};
  assign if0.RegWrite    = reg_write;
  assign if0.WriteAddr   = waddr;
  assign if0.WriteData   = wdata;
  assign if0.SetBusy     = set_busy;
  assign if0.SetBusyAddr = sbaddr;
  assign if0.ReadAddr    = {ra1, ra0};

  scoreboard_regfile #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1)
  );
  scoreboard_regfile #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Abstract model: count reset-free edges; after NREGS of them the file is all-zero and usable.
  logic [31:0] mreg [NREGS];
  logic [31:0] mbusy;
  int          edges = 0;
  bit          started = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      edges   = 0;
      mbusy   = '0;
      started = 1'b1;
    end else if (started) begin
      if (edges < NREGS) begin
        edges++;
        if (edges == NREGS) begin
          for (int i = 0; i < NREGS; i++) mreg[i] = '0;
        end
      end else begin
        if (reg_write && waddr != 0) begin
          mreg[waddr]  = wdata;
          mbusy[waddr] = 1'b0;
        end
        if (set_busy && sbaddr != 0) mbusy[sbaddr] = 1'b1;
      end
    end
  end

  function automatic void exp_read(input int byp, input logic [4:0] a,
                                   output logic [31:0] d, output logic b);
    logic h;
    d = '0;
    b = 1'b0;
    if (edges >= NREGS && a != 0) begin
      h = (byp != 0) && reg_write && (waddr == a);
      d = h ? wdata : mreg[a];
      b = mbusy[a] && !h;
    end
  endfunction

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [31:0] d;
    logic        b;
    logic [4:0]  a;
    if (started) begin
      chk("ready_b1", {31'b0, if1.Ready}, {31'b0, edges >= NREGS});
      chk("ready_b0", {31'b0, if0.Ready}, {31'b0, edges >= NREGS});
      for (int p = 0; p < NRD; p++) begin
        a = (p == 0) ? ra0 : ra1;
        exp_read(1, a, d, b);
        chk($sformatf("b1_rdata%0d", p), if1.ReadData[p*32 +: 32], d);
        chk($sformatf("b1_rbusy%0d", p), {31'b0, if1.ReadBusy[p]}, {31'b0, b});
        exp_read(0, a, d, b);
        chk($sformatf("b0_rdata%0d", p), if0.ReadData[p*32 +: 32], d);
        chk($sformatf("b0_rbusy%0d", p), {31'b0, if0.ReadBusy[p]}, {31'b0, b});
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic sb, input logic [4:0] sa,
                     input logic [4:0] r0, input logic [4:0] r1);
    reg_write = we;
    waddr     = wa;
    wdata     = wd;
    set_busy  = sb;
    sbaddr    = sa;
    ra0       = r0;
    ra1       = r1;
  endtask

  initial begin
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);

    // One-cycle reset, then the full clear sweep with reads held on nonzero addresses.
    nxt();
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 5, 3);
    for (int i = 1; i <= NREGS; i++) begin
      nxt();
      @(negedge clk);
      chk($sformatf("clr_ready_%0d", i), {31'b0, if1.Ready}, (i == NREGS) ? 32'd1 : 32'd0);
      if (i < NREGS) chk("clr_rdata0", if1.ReadData[31:0], 32'h0);
    end

    // Write x5, read back on port 0 while port 1 reads x0.
    nxt(); drv(1, 5, 32'hDEADBEEF, 0, 0, 1, 2);
    nxt(); drv(0, 0, 0, 0, 0, 5, 0);
    @(negedge clk);
    chk("x5_b1_p0", if1.ReadData[31:0],  32'hDEADBEEF);
    chk("x5_b1_p1", if1.ReadData[63:32], 32'h0);
    chk("x5_b0_p0", if0.ReadData[31:0],  32'hDEADBEEF);

    // Same-cycle write and read of x7: forwarded vs old value.
    nxt(); drv(1, 7, 32'h11, 0, 0, 0, 0);
    nxt(); drv(1, 7, 32'h12345678, 0, 0, 7, 0);
    @(negedge clk);
    chk("fwd_b1", if1.ReadData[31:0], 32'h12345678);
    chk("nofwd_b0", if0.ReadData[31:0], 32'h00000011);
    nxt(); drv(0, 0, 0, 0, 0, 7, 0);
    @(negedge clk);
    chk("after_b0", if0.ReadData[31:0], 32'h12345678);

    // Busy tracking on x9.
    nxt(); drv(0, 0, 0, 1, 9, 9, 0);
    nxt(); drv(0, 0, 0, 0, 0, 9, 9);
    @(negedge clk);
    chk("busy9_set", {31'b0, if1.ReadBusy[0]}, 32'd1);
    nxt(); drv(1, 9, 32'h55, 0, 0, 9, 9);
    @(negedge clk);
    chk("busy9_fwd_b1", {31'b0, if1.ReadBusy[0]}, 32'd0);
    chk("busy9_nofwd_b0", {31'b0, if0.ReadBusy[0]}, 32'd1);
    nxt(); drv(0, 0, 0, 0, 0, 9, 9);
    @(negedge clk);
    chk("busy9_clr_b1", {31'b0, if1.ReadBusy[0]}, 32'd0);
    chk("busy9_clr_b0", {31'b0, if0.ReadBusy[1]}, 32'd0);
    chk("x9_data", if1.ReadData[31:0], 32'h55);
    nxt(); drv(1, 9, 32'h66, 1, 9, 9, 0);
    nxt(); drv(0, 0, 0, 0, 0, 9, 9);
    @(negedge clk);
    chk("busy9_prio_p0", {31'b0, if1.ReadBusy[0]}, 32'd1);
    chk("busy9_prio_p1", {31'b0, if0.ReadBusy[1]}, 32'd1);
    chk("x9_prio_data", if1.ReadData[63:32], 32'h66);

    // x0 is hardwired.
    nxt(); drv(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
    @(negedge clk);
    chk("x0_fwd_data", if1.ReadData[31:0], 32'h0);
    chk("x0_fwd_busy", {31'b0, if1.ReadBusy[0]}, 32'd0);
    nxt(); drv(0, 0, 0, 0, 0, 0, 5);
    @(negedge clk);
    chk("x0_data", if1.ReadData[31:0], 32'h0);
    chk("x0_busy", {31'b0, if0.ReadBusy[0]}, 32'd0);
    chk("x5_keep", if1.ReadData[63:32], 32'hDEADBEEF);
    nxt(); drv(1, 3, 32'h33, 0, 0, 5, 5);
    nxt(); drv(0, 0, 0, 0, 0, 3, 5);
    @(negedge clk);
    chk("x3_data", if1.ReadData[31:0], 32'h33);
    chk("x5_p1", if0.ReadData[63:32], 32'hDEADBEEF);

    // Reset from RUN, then reset again at clear cycle 10 with writes pending throughout.
    nxt(); rst = 1'b1;
    nxt(); rst = 1'b0; drv(1, 3, 32'hAAAA, 1, 4, 3, 4);
    @(negedge clk);
    chk("rst_ready", {31'b0, if1.Ready}, 32'd0);
    for (int i = 1; i < 10; i++) nxt();
    nxt(); rst = 1'b1;
    nxt(); rst = 1'b0;
    for (int i = 1; i <= NREGS; i++) begin
      nxt();
      if (i == NREGS) drv(0, 0, 0, 0, 0, 3, 4);
      @(negedge clk);
      chk($sformatf("reclr_ready_%0d", i), {31'b0, if0.Ready}, (i == NREGS) ? 32'd1 : 32'd0);
    end
    chk("x3_lost", if1.ReadData[31:0], 32'h0);
    chk("x4_busy_lost", {31'b0, if1.ReadBusy[1]}, 32'd0);
    nxt(); drv(0, 0, 0, 0, 0, 9, 5);
    @(negedge clk);
    chk("x9_busy_rst", {31'b0, if1.ReadBusy[0]}, 32'd0);
    chk("x5_cleared", if0.ReadData[63:32], 32'h0);

    nxt();
    nxt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/scoreboard_regfile.md
SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width in bits.
REQ-002 SHALL have parameter NREGS, default 32: register count, power of two and at least 2; AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 2: number of read ports, 1..4.
REQ-004 SHALL have parameter BYPASS, default 1: 1 enables write-to-read forwarding, 0 disables it.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port Ready, output, 1 bit: clear sequence done, file usable.
REQ-008 SHALL have port RegWrite, input, 1 bit: write enable.
REQ-009 SHALL have port WriteAddr, input, AW bits: write target.
REQ-010 SHALL have port WriteData, input, XLEN bits: write value.
REQ-011 SHALL have port SetBusy, input, 1 bit: mark a register as pending (producer issued).
REQ-012 SHALL have port SetBusyAddr, input, AW bits: register to mark.
REQ-013 SHALL have port ReadAddr, input, NRD*AW bits: port p uses bits [p*AW +: AW].
REQ-014 SHALL have port ReadData, output, NRD*XLEN bits: port p uses bits [p*XLEN +: XLEN]; combinational.
REQ-015 SHALL have port ReadBusy, output, NRD bits: port p pending flag; combinational.

Function
REQ-016 SHALL implement a two-state FSM, CLEAR and RUN; Ready = 1 only in RUN.
REQ-017 SHALL clear in CLEAR: each clk edge writes zero to register cnt and increments cnt; at the edge where cnt == NREGS-1, go to RUN.
REQ-018 SHALL ignore RegWrite and SetBusy while in CLEAR; while Ready = 0, all ReadData SHALL be 0 and all ReadBusy 0.
REQ-019 SHALL, in RUN, write WriteData to WriteAddr at the clk edge when RegWrite = 1 and WriteAddr != 0.
REQ-020 SHALL hardwire register 0: reads return 0, writes discarded, never busy; SetBusy to address 0 is a no-op.
REQ-021 SHALL, in RUN, return on each port p ReadData = register[ReadAddr p], or 0 when ReadAddr p = 0.
REQ-022 SHALL forward when BYPASS = 1: if RegWrite = 1 and WriteAddr = ReadAddr p != 0 in the same cycle, ReadData p = WriteData. With BYPASS = 0, old contents are returned until the edge.
REQ-023 SHALL keep one busy bit per register: SetBusy sets busy[SetBusyAddr] at the edge, and RegWrite clears busy[WriteAddr] at the edge.
REQ-024 SHALL give SetBusy priority when SetBusy and RegWrite hit the same address in the same cycle: data is written and busy ends at 1.
REQ-025 SHALL drive ReadBusy p = busy[ReadAddr p] AND NOT (BYPASS = 1 and a forwarding hit on port p per REQ-022).
REQ-026 SHALL let all NRD ports read any address independently, including several ports on the same address.

Reset
REQ-027 SHALL, at a clk edge with rst = 1: state goes to CLEAR, cnt goes to 0, all busy bits go to 0, and Ready goes to 0; register contents are not reset in that cycle.
REQ-028 SHALL make Ready rise after exactly NREGS consecutive clk edges with rst = 0 (32 by default).
REQ-029 SHALL restart the clear from register 0 with the full NREGS-edge count if rst is reasserted mid-CLEAR or in RUN.
REQ-030 SHALL not depend on initial blocks for functional reset; simulation-only init is permitted.

Verification
REQ-031 SHALL cover: rst high for 1 cycle, then low -> Ready = 0 for 32 edges and 1 after the 32nd; every read = 0 throughout.
REQ-032 SHALL cover: in RUN, write x5 = 0xDEADBEEF; next cycle ReadAddr0 = 5, ReadAddr1 = 0 -> ReadData0 = 0xDEADBEEF, ReadData1 = 0.
REQ-033 SHALL cover: RegWrite x7 = 0x12345678 with ReadAddr0 = 7 in the same cycle -> BYPASS = 1 gives 0x12345678; BYPASS = 0 gives the old value, then 0x12345678 next cycle.
REQ-034 SHALL cover: SetBusy x9 -> ReadBusy = 1 next cycle; RegWrite x9 = 0x55 -> ReadBusy = 0 in the same cycle (bypass on) and stays 0 after the edge; SetBusy and RegWrite x9 in the same cycle -> busy stays 1, data = the written value.
REQ-035 SHALL cover: rst at clear cycle 10 -> Ready rises 32 edges after the rst deassertion, not 22; writes issued during CLEAR are lost.
REQ-036 SHALL cover: write to x0 = 0xFFFFFFFF and SetBusy x0 -> ReadData = 0 and ReadBusy = 0 at address 0.
